// File: rtl/regfile_param_bypass_if.sv
// ----------------------------------------------------------------------------
// regfile_param_bypass_if
// Groups the ID/WB-side register file signals into one bundle.
//   master : pipeline side, drives read/write indices, write data and enable;
//            observes read data, busy and initDone.
//   slave  : register file side, the mirror image of master.
// Signals:
//   rs1, rs2   read port indices          readData1, readData2  read data
//   rd         write index                writeData, regWrite   write data / enable
//   busy       reset or init sweep active initDone              last sweep write pulse
// ----------------------------------------------------------------------------
interface regfile_param_bypass_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] rs1;
   logic [ADDR_W-1:0] rs2;
   logic [ADDR_W-1:0] rd;
   logic [DATA_W-1:0] writeData;
   logic              regWrite;
   logic [DATA_W-1:0] readData1;
   logic [DATA_W-1:0] readData2;
   logic              busy;
   logic              initDone;

   modport master (
      output rs1, rs2, rd, writeData, regWrite,
      input  readData1, readData2, busy, initDone
   );

   modport slave (
      input  rs1, rs2, rd, writeData, regWrite,
      output readData1, readData2, busy, initDone
   );
endinterface

// File: rtl/regfile_param_bypass.sv
// ----------------------------------------------------------------------------
// regfile_param_bypass
// Parametrised integer register file between the ID and WB stages.
// Two combinational read ports with same-cycle write-to-read bypass, one
// write port, optional hardwired-zero register 0, and a hardware init sweep
// that runs after every synchronous reset.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; restarts the init sweep from entry 0
//   rf     slave side of regfile_param_bypass_if (rs1/rs2/rd/writeData/
//          regWrite in; readData1/readData2/busy/initDone out)
// ----------------------------------------------------------------------------
module regfile_param_bypass #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned NUM_REGS  = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned ZERO_REG  = 1,
   parameter int unsigned INIT_MODE = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   regfile_param_bypass_if.slave  rf
);

   localparam int unsigned        IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   // One extra bit so NUM_REGS == 2**ADDR_W is representable in the range check.
   localparam logic [ADDR_W:0]    NUM_REGS_X = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0]  LAST_PTR   = ADDR_W'(NUM_REGS - 1);

   typedef enum logic {
      INIT,
      READY
   } state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  ptr_q, ptr_d;
   logic               init_done_q, init_done_d;
   logic [DATA_W-1:0]  regs_q [NUM_REGS];

   logic               busy;
   logic               ready_wr;
   logic               wr_en;
   logic [IDX_W-1:0]   wr_idx;
   logic [DATA_W-1:0]  wr_data;

   function automatic logic in_range(input logic [ADDR_W-1:0] idx);
      return {1'b0, idx} < NUM_REGS_X;
   endfunction

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] idx);
      return (ZERO_REG != 0) && (idx == '0);
   endfunction

   function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W-1:0] idx);
      if ((INIT_MODE == 0) || is_zero_reg(idx)) begin
         return '0;
      end
      return DATA_W'(idx) + DATA_W'(1);
   endfunction

   assign busy = (state_q == INIT) || reset;

   // A write from WB that will actually land in the array; also the bypass qualifier.
   assign ready_wr = !busy && rf.regWrite && in_range(rf.rd) && !is_zero_reg(rf.rd);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      init_done_d = 1'b0;
      wr_en       = 1'b0;
      wr_idx      = rf.rd[IDX_W-1:0];
      wr_data     = rf.writeData;
      if (!reset) begin
         unique case (state_q)
            INIT: begin
               wr_en   = 1'b1;
               wr_idx  = ptr_q[IDX_W-1:0];
               wr_data = init_value(ptr_q);
               // Pointer stops at the last entry rather than wrapping.
               if (ptr_q == LAST_PTR) begin
                  state_d     = READY;
                  init_done_d = 1'b1;
               end else begin
                  ptr_d = ptr_q + ADDR_W'(1);
               end
            end
            READY: begin
               wr_en = ready_wr;
            end
            default: begin
               state_d = INIT;
               ptr_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= INIT;
         ptr_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         init_done_q <= init_done_d;
      end
   end

   // Array has no reset: contents survive reset until the sweep overwrites them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         regs_q[wr_idx] <= wr_data;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] rs);
      if (busy || !in_range(rs) || is_zero_reg(rs)) begin
         return '0;
      end
      if (ready_wr && (rf.rd == rs)) begin
         return rf.writeData;
      end
      return regs_q[rs[IDX_W-1:0]];
   endfunction

   always_comb begin
      rf.readData1 = read_port(rf.rs1);
      rf.readData2 = read_port(rf.rs2);
   end

   assign rf.busy     = busy;
   assign rf.initDone = init_done_q;

endmodule

// File: tb/tb_regfile_param_bypass.sv
// ----------------------------------------------------------------------------
// tb_regfile_param_bypass
// Drives two register file instances (default parameters, and a 32-bit,
// 16-entry, no-zero-register, zero-init variant). Expected output values are
// queued as each cycle's inputs are applied and compared on the falling edge.
// ----------------------------------------------------------------------------
module tb_regfile_param_bypass;

   logic clk = 1'b0;
   logic reset0;
   logic reset1;

   always #5 clk = ~clk;

   regfile_param_bypass_if #(.DATA_W(64), .ADDR_W(5)) bus0 ();
   regfile_param_bypass_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

   regfile_param_bypass #(
      .DATA_W(64), .NUM_REGS(32), .ADDR_W(5), .ZERO_REG(1), .INIT_MODE(1)
   ) dut0 (
      .clk   (clk),
      .reset (reset0),
      .rf    (bus0.slave)
   );

   regfile_param_bypass #(
      .DATA_W(32), .NUM_REGS(16), .ADDR_W(5), .ZERO_REG(0), .INIT_MODE(0)
   ) dut1 (
      .clk   (clk),
      .reset (reset1),
      .rf    (bus1.slave)
   );

   // Selector codes for which output an expectation refers to.
   localparam int RD1_0 = 0, RD2_0 = 1, BUSY_0 = 2, DONE_0 = 3;
   localparam int RD1_1 = 4, RD2_1 = 5, BUSY_1 = 6, DONE_1 = 7;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   string       tag_q [$];
   int          sel_q [$];
   logic [63:0] exp_q [$];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input int sel, input logic [63:0] v);
      tag_q.push_back(tag);
      sel_q.push_back(sel);
      exp_q.push_back(v);
   endtask

   function automatic logic [63:0] observe(input int sel);
      case (sel)
         RD1_0:   return bus0.readData1;
         RD2_0:   return bus0.readData2;
         BUSY_0:  return {63'd0, bus0.busy};
         DONE_0:  return {63'd0, bus0.initDone};
         RD1_1:   return {32'd0, bus1.readData1};
         RD2_1:   return {32'd0, bus1.readData2};
         BUSY_1:  return {63'd0, bus1.busy};
         default: return {63'd0, bus1.initDone};
      endcase
   endfunction

   always @(negedge clk) begin
      while (sel_q.size() != 0) begin
         string       t;
         int          s;
         logic [63:0] e;
         t = tag_q.pop_front();
         s = sel_q.pop_front();
         e = exp_q.pop_front();
         check_eq(t, observe(s), e);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [63:0] wd, input logic we);
      bus0.rs1 = rs1; bus0.rs2 = rs2; bus0.rd = rd; bus0.writeData = wd; bus0.regWrite = we;
   endtask

   task automatic drive1(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] wd, input logic we);
      bus1.rs1 = rs1; bus1.rs2 = rs2; bus1.rd = rd; bus1.writeData = wd; bus1.regWrite = we;
   endtask

   initial begin
      reset0 = 1'b1;
      reset1 = 1'b1;
      drive0(5'd5, 5'd6, 5'd0, 64'd0, 1'b0);
      drive1(5'd0, 5'd0, 5'd0, 32'd0, 1'b0);

      // Two reset cycles on dut0.
      step();
      push_exp("rst_busy", BUSY_0, 64'd1);
      push_exp("rst_done", DONE_0, 64'd0);
      push_exp("rst_rd1",  RD1_0,  64'd0);
      step();

      // Sweep: busy for exactly 32 cycles; gated write attempted at ptr=10.
      reset0 = 1'b0;
      for (int c = 0; c < 32; c++) begin
         if (c == 10) begin
            drive0(5'd3, 5'd4, 5'd20, 64'hFF, 1'b1);
            push_exp("gate_rd1", RD1_0, 64'd0);
            push_exp("gate_rd2", RD2_0, 64'd0);
         end else begin
            drive0(5'd3, 5'd4, 5'd0, 64'd0, 1'b0);
         end
         push_exp("sweep_busy", BUSY_0, 64'd1);
         push_exp("sweep_done", DONE_0, 64'd0);
         step();
      end

      drive0(5'd0, 5'd31, 5'd0, 64'd0, 1'b0);
      push_exp("ready_busy", BUSY_0, 64'd0);
      push_exp("done_pulse", DONE_0, 64'd1);
      push_exp("rs1_0",      RD1_0,  64'd0);
      push_exp("rs2_31",     RD2_0,  64'd32);
      step();

      drive0(5'd5, 5'd20, 5'd0, 64'd0, 1'b0);
      push_exp("done_low", DONE_0, 64'd0);
      push_exp("rs1_5",    RD1_0,  64'd6);
      push_exp("gate_drop",RD2_0,  64'd21);
      step();

      // Write with bypass on port 1, untouched neighbour on port 2.
      drive0(5'd7, 5'd8, 5'd7, 64'hDEAD_BEEF, 1'b1);
      push_exp("byp_rd1", RD1_0, 64'hDEAD_BEEF);
      push_exp("byp_rd2", RD2_0, 64'd9);
      step();

      drive0(5'd7, 5'd7, 5'd0, 64'd0, 1'b0);
      push_exp("arr_rd1", RD1_0, 64'hDEAD_BEEF);
      push_exp("arr_rd2", RD2_0, 64'hDEAD_BEEF);
      step();

      // Bypass on both ports at once.
      drive0(5'd9, 5'd9, 5'd9, 64'h0123_4567_89AB_CDEF, 1'b1);
      push_exp("byp2_rd1", RD1_0, 64'h0123_4567_89AB_CDEF);
      push_exp("byp2_rd2", RD2_0, 64'h0123_4567_89AB_CDEF);
      step();

      // Zero register ignores writes and never bypasses.
      drive0(5'd0, 5'd9, 5'd0, 64'h55, 1'b1);
      push_exp("zero_byp", RD1_0, 64'd0);
      push_exp("zero_r9",  RD2_0, 64'h0123_4567_89AB_CDEF);
      step();

      drive0(5'd0, 5'd31, 5'd0, 64'd0, 1'b0);
      push_exp("zero_next", RD1_0, 64'd0);
      push_exp("r31_keep",  RD2_0, 64'd32);
      step();

      // Reset from READY, then again mid-sweep at ptr=15.
      reset0 = 1'b1;
      drive0(5'd7, 5'd9, 5'd0, 64'd0, 1'b0);
      push_exp("rst2_busy", BUSY_0, 64'd1);
      push_exp("rst2_rd1",  RD1_0,  64'd0);
      step();
      reset0 = 1'b0;
      for (int c = 0; c < 15; c++) begin
         push_exp("part_busy", BUSY_0, 64'd1);
         push_exp("part_done", DONE_0, 64'd0);
         step();
      end
      reset0 = 1'b1;
      push_exp("mid_busy", BUSY_0, 64'd1);
      push_exp("mid_done", DONE_0, 64'd0);
      step();
      reset0 = 1'b0;
      for (int c = 0; c < 32; c++) begin
         push_exp("resweep_busy", BUSY_0, 64'd1);
         push_exp("resweep_done", DONE_0, 64'd0);
         step();
      end
      push_exp("resweep_end",  BUSY_0, 64'd0);
      push_exp("resweep_pulse",DONE_0, 64'd1);
      push_exp("reinit_r7",    RD1_0,  64'd8);
      push_exp("reinit_r9",    RD2_0,  64'd10);
      step();
      push_exp("resweep_low", DONE_0, 64'd0);
      step();

      // Second configuration: 16 entries, zero init, ordinary register 0.
      drive1(5'd20, 5'd5, 5'd0, 32'd0, 1'b0);
      push_exp("p_rst_busy", BUSY_1, 64'd1);
      push_exp("p_rst_rd1",  RD1_1,  64'd0);
      step();
      reset1 = 1'b0;
      for (int c = 0; c < 16; c++) begin
         push_exp("p_sweep_busy", BUSY_1, 64'd1);
         push_exp("p_sweep_done", DONE_1, 64'd0);
         step();
      end
      push_exp("p_ready_busy", BUSY_1, 64'd0);
      push_exp("p_done_pulse", DONE_1, 64'd1);
      push_exp("p_rs1_20",     RD1_1,  64'd0);
      push_exp("p_rs2_5",      RD2_1,  64'd0);
      step();

      drive1(5'd0, 5'd15, 5'd0, 32'h1234, 1'b1);
      push_exp("p_done_low", DONE_1, 64'd0);
      push_exp("p_r0_byp",   RD1_1,  64'h1234);
      push_exp("p_r15_init", RD2_1,  64'd0);
      step();

      drive1(5'd0, 5'd15, 5'd15, 32'h77, 1'b1);
      push_exp("p_r0_arr",  RD1_1, 64'h1234);
      push_exp("p_r15_byp", RD2_1, 64'h77);
      step();

      drive1(5'd20, 5'd15, 5'd20, 32'hAAAA, 1'b1);
      push_exp("p_oor_byp", RD1_1, 64'd0);
      push_exp("p_r15_arr", RD2_1, 64'h77);
      step();

      drive1(5'd4, 5'd20, 5'd0, 32'd0, 1'b0);
      push_exp("p_alias_r4", RD1_1, 64'd0);
      push_exp("p_oor_rd",   RD2_1, 64'd0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
